// File: rtl/bist_misr_analyzer.sv
// BIST response analyzer: compacts CUT responses into a MISR over a fixed
// number of accepted responses, then compares the signature against a golden
// value and holds the pass/fail verdict until the next run.
module bist_misr_analyzer #(
    parameter int                RESP_W   = 7,
    parameter int                SIG_W    = 16,
    parameter logic [SIG_W-1:0]  POLY     = 16'h100B,
    parameter logic [SIG_W-1:0]  SEED     = 16'h0000,
    parameter int                PATTERNS = 1024,
    localparam int               CNT_W    = $clog2(PATTERNS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    input  logic [SIG_W-1:0]  golden,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  resp_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_inc_s;

    // One MISR step: shift left, fold in the polynomial when the top bit
    // falls out, and XOR in the zero-extended response word.
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0]  s,
                                                   input logic [RESP_W-1:0] r);
        logic [SIG_W-1:0] fb_term;
        fb_term = s[SIG_W-1] ? POLY : {SIG_W{1'b0}};
        return {s[SIG_W-2:0], 1'b0} ^ fb_term ^ SIG_W'(r);
    endfunction

    assign cnt_inc_s = cnt_q + ONE_CNT;

    // Next-state, signature, count and verdict; abort takes priority over start.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        if (abort) begin
            state_d = ST_IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        sig_d   = SEED;
                        cnt_d   = {CNT_W{1'b0}};
                        pass_d  = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    if (resp_valid) begin
                        sig_d = misr_next(sig_q, resp);
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == LAST_CNT) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_CHECK: begin
                    pass_d  = (sig_q == golden);
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end
            endcase
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= {CNT_W{1'b0}};
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign resp_count = cnt_q;

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Directed bench for bist_misr_analyzer: three instances with different
// PATTERNS/SEED share the stimulus; each scenario resets and checks one.
module tb_bist_misr_analyzer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        resp_valid;
    logic [6:0]  resp;
    logic [15:0] golden;

    logic        a_busy, a_done, a_pass;
    logic [15:0] a_sig;
    logic [2:0]  a_cnt;
    logic        b_busy, b_done, b_pass;
    logic [15:0] b_sig;
    logic [0:0]  b_cnt;
    logic        c_busy, c_done, c_pass;
    logic [15:0] c_sig;
    logic [10:0] c_cnt;

    int n_cmp;
    int n_bad;

    bist_misr_analyzer #(.PATTERNS(4), .SEED(16'h0000)) u_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .resp_valid(resp_valid), .resp(resp), .golden(golden),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .signature(a_sig), .resp_count(a_cnt));

    bist_misr_analyzer #(.PATTERNS(1), .SEED(16'h8000)) u_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .resp_valid(resp_valid), .resp(resp), .golden(golden),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .signature(b_sig), .resp_count(b_cnt));

    bist_misr_analyzer #(.PATTERNS(1024), .SEED(16'h0000)) u_c (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .resp_valid(resp_valid), .resp(resp), .golden(golden),
        .busy(c_busy), .done(c_done), .pass(c_pass),
        .signature(c_sig), .resp_count(c_cnt));

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference MISR step (x^16+x^12+x^3+x+1).
    function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [6:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {9'd0, r};
    endfunction

    // Response word for pattern i of the long run.
    function automatic logic [6:0] stream_word(input int i);
        logic [15:0] x;
        x = 16'(i) * 16'd40503 + 16'h5A3C;
        return x[12:6] ^ x[6:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; resp_valid = 1'b0;
        resp = 7'd0; golden = 16'h0000;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            resp_valid = i[0];
            resp = 7'h55;
            step();
            n_cmp++;
            if (a_sig !== 16'h0000 || a_busy !== 1'b0 || a_done !== 1'b0 ||
                a_pass !== 1'b0 || a_cnt !== 3'd0) begin
                n_bad++;
                $display("FAIL reset_idle cyc%0d: sig=%h busy=%b done=%b pass=%b cnt=%0d, required 0000/0/0/0/0",
                         i, a_sig, a_busy, a_done, a_pass, a_cnt);
            end
        end
        n_cmp++;
        if (b_sig !== 16'h8000) begin
            n_bad++;
            $display("FAIL reset_seed: sig=%h required 8000", b_sig);
        end
    endtask

    task automatic test_shift_chain();
        logic [6:0] vec [4];
        int busy_cycles;
        vec[0] = 7'h01; vec[1] = 7'h00; vec[2] = 7'h00; vec[3] = 7'h00;
        do_reset();
        busy_cycles = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        if (a_busy === 1'b1) busy_cycles++;
        for (int i = 0; i < 4; i++) begin
            resp_valid = 1'b1;
            resp = vec[i];
            step();
            if (a_busy === 1'b1) busy_cycles++;
            n_cmp++;
            if (a_cnt !== 3'(i + 1)) begin
                n_bad++;
                $display("FAIL shift_count%0d: cnt=%0d required %0d", i, a_cnt, i + 1);
            end
        end
        resp = 7'h7F;
        golden = 16'h0008;
        step();
        resp_valid = 1'b0;
        n_cmp++;
        if (busy_cycles !== 5) begin
            n_bad++;
            $display("FAIL shift_busy_len: busy cycles=%0d required 5", busy_cycles);
        end
        n_cmp++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_pass !== 1'b1 ||
            a_sig !== 16'h0008 || a_cnt !== 3'd4) begin
            n_bad++;
            $display("FAIL shift_result: done=%b busy=%b pass=%b sig=%h cnt=%0d, required 1/0/1/0008/4",
                     a_done, a_busy, a_pass, a_sig, a_cnt);
        end
        resp_valid = 1'b1;
        step();
        resp_valid = 1'b0;
        n_cmp++;
        if (a_sig !== 16'h0008 || a_done !== 1'b1) begin
            n_bad++;
            $display("FAIL shift_hold: sig=%h done=%b required 0008/1", a_sig, a_done);
        end
    endtask

    task automatic test_feedback();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        resp_valid = 1'b1;
        resp = 7'h00;
        step();
        resp_valid = 1'b0;
        n_cmp++;
        if (b_sig !== 16'h100B || b_cnt !== 1'b1 || b_busy !== 1'b1 || b_done !== 1'b0) begin
            n_bad++;
            $display("FAIL fb_sig: sig=%h cnt=%0d busy=%b done=%b required 100B/1/1/0",
                     b_sig, b_cnt, b_busy, b_done);
        end
        golden = 16'h100B;
        step();
        n_cmp++;
        if (b_done !== 1'b1 || b_pass !== 1'b1) begin
            n_bad++;
            $display("FAIL fb_pass: done=%b pass=%b required 1/1", b_done, b_pass);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if (b_done !== 1'b0 || b_pass !== 1'b0 || b_sig !== 16'h8000 || b_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL fb_restart: done=%b pass=%b sig=%h busy=%b required 0/0/8000/1",
                     b_done, b_pass, b_sig, b_busy);
        end
        resp_valid = 1'b1;
        resp = 7'h00;
        step();
        resp_valid = 1'b0;
        golden = 16'h100A;
        step();
        n_cmp++;
        if (b_done !== 1'b1 || b_pass !== 1'b0 || b_sig !== 16'h100B) begin
            n_bad++;
            $display("FAIL fb_wrong_golden: done=%b pass=%b sig=%h required 1/0/100B",
                     b_done, b_pass, b_sig);
        end
    endtask

    task automatic test_stalls();
        logic [6:0] vec [4];
        int gaps [4];
        logic [15:0] exp_sig;
        vec[0] = 7'h01; vec[1] = 7'h00; vec[2] = 7'h00; vec[3] = 7'h00;
        gaps[0] = 1; gaps[1] = 2; gaps[2] = 3; gaps[3] = 0;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_sig = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            resp_valid = 1'b1;
            resp = vec[i];
            step();
            exp_sig = ref_misr(exp_sig, vec[i]);
            for (int g = 0; g < gaps[i]; g++) begin
                resp_valid = 1'b0;
                resp = 7'h3C;
                step();
                n_cmp++;
                if (a_cnt !== 3'(i + 1) || a_sig !== exp_sig) begin
                    n_bad++;
                    $display("FAIL stall_hold r%0d g%0d: cnt=%0d sig=%h required %0d/%h",
                             i, g, a_cnt, a_sig, i + 1, exp_sig);
                end
            end
        end
        resp_valid = 1'b0;
        golden = 16'h0008;
        step();
        n_cmp++;
        if (a_sig !== 16'h0008 || a_pass !== 1'b1 || a_done !== 1'b1 || a_cnt !== 3'd4) begin
            n_bad++;
            $display("FAIL stall_result: sig=%h pass=%b done=%b cnt=%0d required 0008/1/1/4",
                     a_sig, a_pass, a_done, a_cnt);
        end
    endtask

    task automatic test_abort_restart();
        logic [15:0] exp_sig;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_sig = 16'h0000;
        for (int i = 0; i < 100; i++) begin
            resp_valid = 1'b1;
            resp = stream_word(i);
            exp_sig = ref_misr(exp_sig, resp);
            step();
        end
        resp_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (c_busy !== 1'b0 || c_done !== 1'b0 || c_pass !== 1'b0 ||
            c_cnt !== 11'd100 || c_sig !== exp_sig) begin
            n_bad++;
            $display("FAIL abort_state: busy=%b done=%b pass=%b cnt=%0d sig=%h required 0/0/0/100/%h",
                     c_busy, c_done, c_pass, c_cnt, c_sig, exp_sig);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if (c_busy !== 1'b1 || c_cnt !== 11'd0 || c_sig !== 16'h0000) begin
            n_bad++;
            $display("FAIL abort_restart: busy=%b cnt=%0d sig=%h required 1/0/0000",
                     c_busy, c_cnt, c_sig);
        end
        abort = 1'b1;
        step();
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (c_busy !== 1'b0 || c_done !== 1'b0) begin
            n_bad++;
            $display("FAIL start_abort_idle: busy=%b done=%b required 0/0", c_busy, c_done);
        end
    endtask

    task automatic run_long(input logic flip, input logic [15:0] gold,
                            output logic [15:0] model_sig);
        logic [6:0] w;
        start = 1'b1;
        step();
        start = 1'b0;
        model_sig = 16'h0000;
        for (int i = 0; i < 1024; i++) begin
            w = stream_word(i);
            if (flip && i == 500) w[3] = ~w[3];
            model_sig = ref_misr(model_sig, w);
            resp_valid = 1'b1;
            resp = w;
            step();
        end
        resp_valid = 1'b0;
        golden = gold;
        step();
    endtask

    task automatic test_end_to_end();
        logic [15:0] good_sig;
        logic [15:0] bad_sig;
        do_reset();
        good_sig = 16'h0000;
        for (int i = 0; i < 1024; i++) good_sig = ref_misr(good_sig, stream_word(i));
        run_long(1'b0, good_sig, bad_sig);
        n_cmp++;
        if (c_done !== 1'b1 || c_pass !== 1'b1 || c_sig !== good_sig || c_cnt !== 11'd1024) begin
            n_bad++;
            $display("FAIL e2e_good: done=%b pass=%b sig=%h cnt=%0d required 1/1/%h/1024",
                     c_done, c_pass, c_sig, c_cnt, good_sig);
        end
        run_long(1'b1, good_sig, bad_sig);
        n_cmp++;
        if (c_done !== 1'b1 || c_pass !== 1'b0 || c_sig !== bad_sig) begin
            n_bad++;
            $display("FAIL e2e_flip: done=%b pass=%b sig=%h required 1/0/%h",
                     c_done, c_pass, c_sig, bad_sig);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; resp_valid = 1'b0;
        resp = 7'd0; golden = 16'h0000;
        test_reset();
        test_shift_chain();
        test_feedback();
        test_stalls();
        test_abort_restart();
        test_end_to_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
